// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
    typedef enum logic {OWN_M0, OWN_M1} arb_owner_t;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/dmem_arbiter_starve_ctr.sv
// Saturating counter of consecutive M0 grants taken while M1 was waiting.
module arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign at_limit_o = (cnt_q == CW'(LIMIT));

    // Clear wins over increment; hold once the limit is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && !at_limit_o)
            cnt_d = cnt_q + CW'(1);
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a comb-read / sync-write data memory.
// M0 (cpu) has priority; M1 (loader) is forced through after STARVE_LIMIT
// consecutive M0 grants taken while it was waiting.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_valid,
    output logic              m0_ready,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_rsp_valid,
    output logic [DATA_W-1:0] m0_rsp_rdata,
    input  logic              m1_valid,
    output logic              m1_ready,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_rsp_valid,
    output logic [DATA_W-1:0] m1_rsp_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              busy
);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic arb_pt, m0_win, m1_win, accept, at_limit;

    // Grant is open in IDLE and RESP; gated by reset so ready reads 0 while held.
    assign arb_pt   = reset && (state_q != ACCESS);
    assign m1_win   = arb_pt && m1_valid && (!m0_valid || at_limit);
    assign m0_win   = arb_pt && m0_valid && !m1_win;
    assign accept   = m0_win || m1_win;
    assign m0_ready = m0_win;
    assign m1_ready = m1_win;

    arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk       (clk),
        .rst_n     (reset),
        .inc_i     (m0_win && m1_valid),
        .clr_i     (arb_pt && (m1_win || !m1_valid)),
        .at_limit_o(at_limit)
    );

    // Next state: one memory cycle, one response cycle, optional back-to-back accept.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = accept ? ACCESS : IDLE;
            ACCESS:  state_d = RESP;
            RESP:    state_d = accept ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command capture on accept; read data captured at the end of ACCESS.
    always_comb begin
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (m1_win) begin
            owner_d = OWN_M1;
            we_d    = m1_we;
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
        end else if (m0_win) begin
            owner_d = OWN_M0;
            we_d    = m0_we;
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
        end
        if (state_q == ACCESS)
            rdata_d = we_q ? '0 : mem_rd;
    end

    // State and command registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= OWN_M0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory port is driven only during ACCESS so no stray write can occur.
    assign mem_we = (state_q == ACCESS) && we_q;
    assign mem_a  = (state_q == ACCESS) ? addr_q  : '0;
    assign mem_wd = (state_q == ACCESS) ? wdata_q : '0;

    assign m0_rsp_valid = (state_q == RESP) && (owner_q == OWN_M0);
    assign m1_rsp_valid = (state_q == RESP) && (owner_q == OWN_M1);
    assign m0_rsp_rdata = m0_rsp_valid ? rdata_q : '0;
    assign m1_rsp_rdata = m1_rsp_valid ? rdata_q : '0;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench: drivers feed request queues, a negedge monitor predicts
// grants/memory port/responses from a transaction-level model.
module tb_dmem_arbiter;

    localparam int LIMIT = 4;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;
    typedef struct { logic [31:0] rdata; int cyc; } exp_t;

    logic        clk = 0, rst_n = 0;
    logic        m0_valid = 0, m0_we = 0, m1_valid = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic        m0_ready, m1_ready, m0_rsp_valid, m1_rsp_valid, mem_we, busy;
    logic [31:0] m0_rsp_rdata, m1_rsp_rdata, mem_a, mem_wd, mem_rd;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];

    req_t q0[$], q1[$], cur;
    exp_t sb0[$], sb1[$];
    int   glog[$], acyc[$];
    int   nchk = 0, nerr = 0, cyc = 0, last_acc = -100, waits = 0;
    logic acc0 = 0, acc1 = 0, in_rst = 1, gap = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(rst_n),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    // Data memory model: combinational read, write on rising edge.
    assign mem_rd = mem[mem_a[9:2]];
    always @(posedge clk) if (mem_we) mem[mem_a[9:2]] = mem_wd;

    initial forever begin @(posedge clk); cyc++; end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Requester 0 driver: present next queued request, hold until accepted.
    initial forever begin
        @(posedge clk); #1;
        if (!rst_n) m0_valid = 0;
        else begin
            if (acc0) begin acc0 = 0; m0_valid = 0; m0_addr = $urandom; end
            if (!m0_valid && q0.size() > 0 && (!gap || $urandom_range(3) != 0)) begin
                cur_drive0: begin
                    req_t r;
                    r = q0.pop_front();
                    m0_valid = 1; m0_we = r.we; m0_addr = r.addr; m0_wdata = r.wdata;
                end
            end
        end
    end

    // Requester 1 driver.
    initial forever begin
        @(posedge clk); #1;
        if (!rst_n) m1_valid = 0;
        else begin
            if (acc1) begin acc1 = 0; m1_valid = 0; m1_addr = $urandom; end
            if (!m1_valid && q1.size() > 0 && (!gap || $urandom_range(3) != 0)) begin
                cur_drive1: begin
                    req_t r;
                    r = q1.pop_front();
                    m1_valid = 1; m1_we = r.we; m1_addr = r.addr; m1_wdata = r.wdata;
                end
            end
        end
    end

    // Accepted request: apply to reference memory in acceptance order, expect response 2 cycles later.
    task automatic record(input int own, input req_t r);
        exp_t e;
        e.rdata = r.we ? 32'd0 : ref_mem[r.addr[9:2]];
        e.cyc   = cyc + 2;
        if (r.we) ref_mem[r.addr[9:2]] = r.wdata;
        if (own == 0) begin sb0.push_back(e); acc0 = 1; end
        else begin sb1.push_back(e); acc1 = 1; end
        last_acc = cyc;
        cur = r;
        glog.push_back(own);
        acyc.push_back(cyc);
    endtask

    // Monitor: checks every output once per cycle on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!in_rst) begin
            logic in_acc, e0, e1;
            exp_t e;
            in_acc = (cyc == last_acc + 1);
            e1 = !in_acc && m1_valid && (!m0_valid || waits == LIMIT);
            e0 = !in_acc && m0_valid && !e1;
            chk1("m0_ready", m0_ready, e0);
            chk1("m1_ready", m1_ready, e1);
            chk1("busy", busy, in_acc || (cyc == last_acc + 2));
            if (in_acc) begin
                chk1("mem_we", mem_we, cur.we);
                chk("mem_a", mem_a, cur.addr);
                chk("mem_wd", mem_wd, cur.wdata);
            end else begin
                chk1("mem_we_idle", mem_we, 1'b0);
                chk("mem_a_idle", mem_a, 32'd0);
                chk("mem_wd_idle", mem_wd, 32'd0);
            end
            if (m0_rsp_valid) begin
                if (sb0.size() == 0) chk1("m0_rsp_unexpected", m0_rsp_valid, 1'b0);
                else begin
                    e = sb0.pop_front();
                    chk("m0_rsp_rdata", m0_rsp_rdata, e.rdata);
                    chk("m0_rsp_cycle", cyc, e.cyc);
                end
            end else begin
                chk("m0_rdata_idle", m0_rsp_rdata, 32'd0);
                if (sb0.size() > 0 && sb0[0].cyc <= cyc) begin
                    chk1("m0_rsp_missing", m0_rsp_valid, 1'b1);
                    void'(sb0.pop_front());
                end
            end
            if (m1_rsp_valid) begin
                if (sb1.size() == 0) chk1("m1_rsp_unexpected", m1_rsp_valid, 1'b0);
                else begin
                    e = sb1.pop_front();
                    chk("m1_rsp_rdata", m1_rsp_rdata, e.rdata);
                    chk("m1_rsp_cycle", cyc, e.cyc);
                end
            end else begin
                chk("m1_rdata_idle", m1_rsp_rdata, 32'd0);
                if (sb1.size() > 0 && sb1[0].cyc <= cyc) begin
                    chk1("m1_rsp_missing", m1_rsp_valid, 1'b1);
                    void'(sb1.pop_front());
                end
            end
            // Starvation bookkeeping: M0 wins while M1 waits counts; M1 win or M1 absent resets.
            if (!in_acc) begin
                if (e0 && m1_valid && waits < LIMIT) waits++;
                if (e1 || !m1_valid) waits = 0;
            end
            if (m0_valid && m0_ready) record(0, '{m0_we, m0_addr, m0_wdata});
            else if (m1_valid && m1_ready) record(1, '{m1_we, m1_addr, m1_wdata});
        end
    end

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (q0.size() == 0 && q1.size() == 0 && !m0_valid && !m1_valid &&
                sb0.size() == 0 && sb1.size() == 0) return;
        end
        nchk++; nerr++;
        $display("FAIL wait_idle: timeout after %0d cycles", budget);
    endtask

    initial begin
        int g, pat [12];
        logic hit;
        req_t r;
        pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom; ref_mem[i] = mem[i];
        end
        // Reset state: all outputs 0 even with a request pending.
        #1 m0_valid = 1; m1_valid = 1;
        #1;
        chk1("rst_m0_ready", m0_ready, 1'b0);
        chk1("rst_m1_ready", m1_ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk1("rst_m0_rsp", m0_rsp_valid, 1'b0);
        m0_valid = 0; m1_valid = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1; in_rst = 0;

        // 1: write then read same address.
        q0.push_back('{1'b1, 32'h10, 32'hDEADBEEF});
        q0.push_back('{1'b0, 32'h10, 32'h0});
        wait_idle(50);
        chk("t1_mem", mem[4], 32'hDEADBEEF);

        // 2: simultaneous requests, M0 first then M1.
        g = glog.size();
        q0.push_back('{1'b1, 32'h24, 32'hA5A5_0001});
        q1.push_back('{1'b0, 32'h20, 32'h0});
        wait_idle(50);
        chk("t2_first", 32'(glog[g]), 32'd0);
        chk("t2_second", 32'(glog[g+1]), 32'd1);

        // 3: both continuously requesting -> M0 x4, M1, repeating.
        g = glog.size();
        for (int i = 0; i < 10; i++) q0.push_back('{1'b0, 32'(i * 4), 32'h0});
        for (int i = 0; i < 2; i++) q1.push_back('{1'b0, 32'(64 + i * 4), 32'h0});
        wait_idle(100);
        for (int k = 0; k < 12; k++) chk("t3_grant", 32'(glog[g+k]), 32'(pat[k]));

        // 4: back-to-back reads accept every 2 cycles.
        g = acyc.size();
        for (int i = 0; i < 3; i++) q0.push_back('{1'b0, 32'(i * 4), 32'h0});
        wait_idle(50);
        chk("t4_gap_a", 32'(acyc[g+1] - acyc[g]), 32'd2);
        chk("t4_gap_b", 32'(acyc[g+2] - acyc[g+1]), 32'd2);

        // 5: reset during the ACCESS cycle of a write.
        q0.push_back('{1'b1, 32'h40, 32'h1234_5678});
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk); #1;
            if (cyc == last_acc + 1 && cur.we) hit = 1;
        end
        chk1("t5_in_access", hit, 1'b1);
        #1 rst_n = 0; in_rst = 1;
        #1;
        chk1("t5_mem_we", mem_we, 1'b0);
        chk("t5_mem_a", mem_a, 32'd0);
        chk1("t5_busy", busy, 1'b0);
        chk1("t5_rsp", m0_rsp_valid, 1'b0);
        q0.delete(); q1.delete(); sb0.delete(); sb1.delete();
        acc0 = 0; acc1 = 0; last_acc = -100; waits = 0;
        mem[16] = 32'h0BAD_F00D; ref_mem[16] = 32'h0BAD_F00D;
        @(posedge clk); #2 rst_n = 1; in_rst = 0;
        @(negedge clk); #1;
        chk1("t5_busy_after", busy, 1'b0);
        repeat (4) @(negedge clk);

        // 6: idle bus for 10 cycles; monitor checks all outputs stay 0.
        repeat (10) @(negedge clk);

        // Randomized mix with gaps and read-after-write hits.
        gap = 1;
        for (int i = 0; i < 150; i++) begin
            r.we = 1'($urandom_range(1));
            r.addr = 32'($urandom_range(15)) << 2;
            r.wdata = $urandom;
            if ($urandom_range(1) == 1) q0.push_back(r); else q1.push_back(r);
        end
        wait_idle(2000);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
